animated_square: RTL and testbench
==================================

// Module: animated_square
// PURPOSE
//  Parametrised square sprite for the 96x64 OLED pixel pipeline; successor to the fixed centred square.
//  Per-pixel colour lookup from pixel_index, with a movable position and four modes:
//  static, button-driven, self-bouncing and blinking.
//  Sits between the OLED driver's pixel_index output and the colour mux feeding pixel_data.
// PARAMETERS
//  SCREEN_W   96      display width in pixels
//  SCREEN_H   64      display height in pixels
//  SIZE       13      square side length in pixels (1..SCREEN_H)
//  INIT_X     42      top-left x at reset (0..SCREEN_W-SIZE)
//  INIT_Y     26      top-left y at reset (0..SCREEN_H-SIZE)
//  STEP       1       pixels moved per position update
//  FRAME_DIV  4       frame ticks per bounce step / blink toggle (>=1)
//  BG_COLOR   16'h0   colour driven outside the square
// PORTS
//  clk25       in   1   pixel clock
//  rst_n       in   1   asynchronous, active-low reset
//  pixel_index in   13  current OLED pixel, row-major, 0..SCREEN_W*SCREEN_H-1
//  color_in    in   16  RGB565 fill colour
//  mode        in   2   00 STATIC, 01 MANUAL, 10 BOUNCE, 11 BLINK
//  btn_up/btn_down/btn_left/btn_right  in  1 each  single-cycle debounced pulses
//  color       out  16  RGB565 pixel colour, registered
//  pos_x       out  7   current top-left x
//  pos_y       out  6   current top-left y
// BEHAVIOUR
//  Reset (async assert, sync release):
//   color=BG_COLOR, pos_x=INIT_X, pos_y=INIT_Y, dir_x=dir_y=+1, visible=1, div_cnt=0,
//   pending move flags=0, prev_index=0.
//  Pixel path, latency 1 cycle:
//   x=pixel_index%SCREEN_W, y=pixel_index/SCREEN_W.
//   color <= (visible && pos_x<=x<=pos_x+SIZE-1 && pos_y<=y<=pos_y+SIZE-1) ? color_in : BG_COLOR.
//   Comparisons are done at >=8 bits so no wrap occurs.
//  frame_tick:
//   one-cycle pulse when pixel_index==0 && prev_index!=0.
//   No tick in the first cycle after reset.
//  Position and visibility change only on frame_tick, so there is no tearing within a frame.
//  Mode register mode_q <= mode. Any change of mode_q clears div_cnt and pending flags, sets visible=1,
//   keeps position and direction.
//  STATIC: position frozen; button pulses ignored.
//  MANUAL:
//   - A button pulse sets its pending flag; several pulses in one frame collapse to one STEP.
//   - On frame_tick apply the pending moves, clamp to [0, SCREEN_W-SIZE] x [0, SCREEN_H-SIZE],
//     then clear the flags.
//   - up+down both pending cancel vertically; left+right both pending cancel horizontally.
//   - A pulse in the same cycle as frame_tick is kept for the next frame.
//  BOUNCE:
//   - div_cnt counts frame ticks 0..FRAME_DIV-1.
//   - On the wrap: pos += dir*STEP per axis.
//   - If the result would leave the bounds, clamp to the edge and negate that axis's dir.
//   - Corner hit reverses both axes in the same update.
//  BLINK: position frozen; visible toggles on each div_cnt wrap.
//  All other modes force visible=1.
//  Reset mid-frame: outputs return to reset values immediately; operation resumes on the next frame.
// STRUCTURE
//  Shared package oled_pkg:
//   - OLED_W=96, OLED_H=64, PIX_IDX_W=13
//   - MODE_* localparams (2-bit encodings)
//   - RGB565 colour constants
//  Sub-module frame_tick_gen (pixel_index, prev register -> frame_tick); reused by other sprites.
//  Top holds the mode/position/direction/div registers and the registered colour compare.
// TESTING
//  1. Reset, mode=STATIC, color_in=16'hF800, sweep indices 0..6143 twice:
//     colour F800 exactly at x 42..54, y 26..38, 0 elsewhere, 1-cycle lag; pos stays (42,26).
//  2. MANUAL, 3 btn_right pulses in one frame: pos_x=43 after the next tick (not 45).
//     btn_left with pos_x=0: stays 0. btn_up+btn_down together: pos_y unchanged.
//  3. BOUNCE, FRAME_DIV=1, start (82,26):
//     ticks give pos_x 83, then clamp at 83 (=96-13) with dir_x=-1, then 82.
//     Corner start (83,51) reverses both dirs.
//  4. BLINK, FRAME_DIV=2: square visible frames 0-1, blank 2-3, visible 4-5.
//     Switch to STATIC while blank: visible=1 at once.
//  5. Assert rst_n low mid-frame at pixel_index=3000 after moving:
//     color=0 and pos=(42,26) in the same cycle; no frame_tick on the first post-reset cycle.
//  6. Pulse btn_down in the same cycle as frame_tick: move applied on the following tick, not lost.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared OLED 96x64 definitions: geometry, sprite mode encodings, RGB565 colours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oled_pkg;

    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int PIX_IDX_W = 13;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC = 2'b00;
    localparam mode_t MODE_MANUAL = 2'b01;
    localparam mode_t MODE_BOUNCE = 2'b10;
    localparam mode_t MODE_BLINK  = 2'b11;

    localparam logic [15:0] RGB_BLACK = 16'h0000;
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_GREEN = 16'h07E0;
    localparam logic [15:0] RGB_BLUE  = 16'h001F;
    localparam logic [15:0] RGB_WHITE = 16'hFFFF;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-start detector: pulses when the pixel index returns to 0 from a nonzero index.
// Latency: combinational on the current index against the registered previous index.
// Backpressure: none; consumes one pixel index per clock.
//
// Ports:
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_pixel_index  current OLED pixel index
//   o_frame_tick   one-cycle frame-start pulse
module frame_tick_gen
    import oled_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [PIX_IDX_W-1:0] i_pixel_index,
    output logic                 o_frame_tick
);

    logic [PIX_IDX_W-1:0] r_prev_index;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_index <= '0;
        end else begin
            r_prev_index <= i_pixel_index;
        end
    end

    // Previous index resets to 0, so an index of 0 right after reset is not a frame start.
    assign o_frame_tick = (i_pixel_index == '0) && (r_prev_index != '0);

endmodule

// File: rtl/animated_square.sv
// Square sprite for the 96x64 OLED pipeline with static, manual, bouncing and blinking modes.
// Latency: 1 cycle from pixel index to registered colour; position/visibility update on frame start.
// Backpressure: none; one pixel per clock, button pulses are latched until the next frame.
//
// Ports:
//   i_clk25        pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_pixel_index  current pixel, row-major
//   i_color_in     RGB565 fill colour
//   i_mode         00 static, 01 manual, 10 bounce, 11 blink
//   i_btn_*        single-cycle debounced button pulses
//   o_color        registered RGB565 pixel colour
//   o_pos_x/y      current top-left corner of the square
module animated_square
    import oled_pkg::*;
#(
    parameter int          SCREEN_W  = OLED_W,
    parameter int          SCREEN_H  = OLED_H,
    parameter int          SIZE      = 13,
    parameter int          INIT_X    = 42,
    parameter int          INIT_Y    = 26,
    parameter int          STEP      = 1,
    parameter int          FRAME_DIV = 4,
    parameter logic [15:0] BG_COLOR  = RGB_BLACK
) (
    input  logic                 i_clk25,
    input  logic                 i_rst_n,
    input  logic [PIX_IDX_W-1:0] i_pixel_index,
    input  logic [15:0]          i_color_in,
    input  logic [1:0]           i_mode,
    input  logic                 i_btn_up,
    input  logic                 i_btn_down,
    input  logic                 i_btn_left,
    input  logic                 i_btn_right,
    output logic [15:0]          o_color,
    output logic [6:0]           o_pos_x,
    output logic [5:0]           o_pos_y
);

    localparam int X_MAX = SCREEN_W - SIZE;
    localparam int Y_MAX = SCREEN_H - SIZE;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    // Bit positions inside the pending-move vector.
    localparam int B_UP = 3;
    localparam int B_DN = 2;
    localparam int B_LT = 1;
    localparam int B_RT = 0;

    logic [15:0]          r_color;
    logic [6:0]           r_pos_x;
    logic [5:0]           r_pos_y;
    logic                 r_dir_x_neg;
    logic                 r_dir_y_neg;
    logic                 r_visible;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [3:0]           r_pend;
    mode_t                r_mode_q;

    logic                 w_frame_tick;
    logic                 w_div_wrap;
    logic [3:0]           w_btn;
    logic [PIX_IDX_W-1:0] w_x;
    logic [PIX_IDX_W-1:0] w_y;
    logic                 w_hit;
    int                   w_mx;
    int                   w_my;
    int                   w_bx;
    int                   w_by;
    logic                 w_bdx_neg;
    logic                 w_bdy_neg;

    frame_tick_gen u_tick (
        .i_clk         (i_clk25),
        .i_rst_n       (i_rst_n),
        .i_pixel_index (i_pixel_index),
        .o_frame_tick  (w_frame_tick)
    );

    assign w_btn      = {i_btn_up, i_btn_down, i_btn_left, i_btn_right};
    assign w_div_wrap = (r_div_cnt == DIV_W'(FRAME_DIV - 1));

    // Coordinates kept at full index width so pos+SIZE-1 cannot wrap.
    assign w_x = i_pixel_index % PIX_IDX_W'(SCREEN_W);
    assign w_y = i_pixel_index / PIX_IDX_W'(SCREEN_W);

    assign w_hit = r_visible
                && (w_x >= PIX_IDX_W'(r_pos_x))
                && (w_x <= PIX_IDX_W'(r_pos_x) + PIX_IDX_W'(SIZE - 1))
                && (w_y >= PIX_IDX_W'(r_pos_y))
                && (w_y <= PIX_IDX_W'(r_pos_y) + PIX_IDX_W'(SIZE - 1));

    // Next position candidates for manual and bounce modes, computed signed so
    // that underflow below 0 is visible before clamping.
    always_comb begin
        w_mx = int'(r_pos_x);
        w_my = int'(r_pos_y);
        if (r_pend[B_RT] && !r_pend[B_LT]) begin
            w_mx = w_mx + STEP;
        end else if (r_pend[B_LT] && !r_pend[B_RT]) begin
            w_mx = w_mx - STEP;
        end
        if (r_pend[B_DN] && !r_pend[B_UP]) begin
            w_my = w_my + STEP;
        end else if (r_pend[B_UP] && !r_pend[B_DN]) begin
            w_my = w_my - STEP;
        end
        if (w_mx > X_MAX) begin
            w_mx = X_MAX;
        end else if (w_mx < 0) begin
            w_mx = 0;
        end
        if (w_my > Y_MAX) begin
            w_my = Y_MAX;
        end else if (w_my < 0) begin
            w_my = 0;
        end

        w_bx      = int'(r_pos_x) + (r_dir_x_neg ? -STEP : STEP);
        w_by      = int'(r_pos_y) + (r_dir_y_neg ? -STEP : STEP);
        w_bdx_neg = r_dir_x_neg;
        w_bdy_neg = r_dir_y_neg;
        if (w_bx > X_MAX) begin
            w_bx      = X_MAX;
            w_bdx_neg = 1'b1;
        end else if (w_bx < 0) begin
            w_bx      = 0;
            w_bdx_neg = 1'b0;
        end
        if (w_by > Y_MAX) begin
            w_by      = Y_MAX;
            w_bdy_neg = 1'b1;
        end else if (w_by < 0) begin
            w_by      = 0;
            w_bdy_neg = 1'b0;
        end
    end

    always_ff @(posedge i_clk25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_color     <= BG_COLOR;
            r_pos_x     <= 7'(INIT_X);
            r_pos_y     <= 6'(INIT_Y);
            r_dir_x_neg <= 1'b0;
            r_dir_y_neg <= 1'b0;
            r_visible   <= 1'b1;
            r_div_cnt   <= '0;
            r_pend      <= '0;
            r_mode_q    <= MODE_STATIC;
        end else begin
            r_color  <= w_hit ? i_color_in : BG_COLOR;
            r_mode_q <= i_mode;

            if (i_mode != r_mode_q) begin
                // Mode switch restarts the divider and drops queued moves,
                // but the square stays where it is.
                r_div_cnt <= '0;
                r_pend    <= '0;
                r_visible <= 1'b1;
            end else begin
                case (r_mode_q)
                    MODE_MANUAL: begin
                        r_visible <= 1'b1;
                        if (w_frame_tick) begin
                            r_pos_x <= 7'(w_mx);
                            r_pos_y <= 6'(w_my);
                            // A pulse coinciding with the tick belongs to the next frame.
                            r_pend  <= w_btn;
                        end else begin
                            r_pend  <= r_pend | w_btn;
                        end
                    end
                    MODE_BOUNCE: begin
                        r_visible <= 1'b1;
                        if (w_frame_tick) begin
                            if (w_div_wrap) begin
                                r_div_cnt   <= '0;
                                r_pos_x     <= 7'(w_bx);
                                r_pos_y     <= 6'(w_by);
                                r_dir_x_neg <= w_bdx_neg;
                                r_dir_y_neg <= w_bdy_neg;
                            end else begin
                                r_div_cnt <= r_div_cnt + 1'b1;
                            end
                        end
                    end
                    MODE_BLINK: begin
                        if (w_frame_tick) begin
                            if (w_div_wrap) begin
                                r_div_cnt <= '0;
                                r_visible <= ~r_visible;
                            end else begin
                                r_div_cnt <= r_div_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_visible <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_color = r_color;
    assign o_pos_x = r_pos_x;
    assign o_pos_y = r_pos_y;

endmodule

// File: tb/tb_animated_square.sv
module tb_animated_square;
    import oled_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [12:0] idx;
    logic [15:0] col_in;
    logic [1:0]  mode;
    logic        bu, bd, bl, br;

    logic [15:0] c_dut, c_bnc, c_cor, c_blk;
    logic [6:0]  x_dut, x_bnc, x_cor, x_blk;
    logic [5:0]  y_dut, y_bnc, y_cor, y_blk;

    int errors = 0;
    int checks = 0;
    int bad;
    logic [15:0] exp_c;

    animated_square u_dut (
        .i_clk25(clk), .i_rst_n(rst_n), .i_pixel_index(idx), .i_color_in(col_in), .i_mode(mode),
        .i_btn_up(bu), .i_btn_down(bd), .i_btn_left(bl), .i_btn_right(br),
        .o_color(c_dut), .o_pos_x(x_dut), .o_pos_y(y_dut)
    );
    animated_square #(.INIT_X(82), .INIT_Y(26), .FRAME_DIV(1)) u_bnc (
        .i_clk25(clk), .i_rst_n(rst_n), .i_pixel_index(idx), .i_color_in(col_in), .i_mode(mode),
        .i_btn_up(bu), .i_btn_down(bd), .i_btn_left(bl), .i_btn_right(br),
        .o_color(c_bnc), .o_pos_x(x_bnc), .o_pos_y(y_bnc)
    );
    animated_square #(.INIT_X(83), .INIT_Y(51), .FRAME_DIV(1)) u_cor (
        .i_clk25(clk), .i_rst_n(rst_n), .i_pixel_index(idx), .i_color_in(col_in), .i_mode(mode),
        .i_btn_up(bu), .i_btn_down(bd), .i_btn_left(bl), .i_btn_right(br),
        .o_color(c_cor), .o_pos_x(x_cor), .o_pos_y(y_cor)
    );
    animated_square #(.FRAME_DIV(2)) u_blk (
        .i_clk25(clk), .i_rst_n(rst_n), .i_pixel_index(idx), .i_color_in(col_in), .i_mode(mode),
        .i_btn_up(bu), .i_btn_down(bd), .i_btn_left(bl), .i_btn_right(br),
        .o_color(c_blk), .o_pos_x(x_blk), .o_pos_y(y_blk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel index and advance past the next rising edge.
    task automatic cyc(input int i);
        idx = 13'(i);
        @(posedge clk);
        #1;
    endtask

    // One frame: nonzero index with optional button pulses {up,down,left,right}, then index 0.
    task automatic btn_frame(input logic [3:0] b);
        {bu, bd, bl, br} = b;
        cyc(1);
        {bu, bd, bl, br} = 4'b0000;
        cyc(0);
    endtask

    function automatic bit in_sq(input int i, input int px, input int py);
        int x, y;
        x = i % 96;
        y = i / 96;
        return (x >= px) && (x <= px + 12) && (y >= py) && (y <= py + 12);
    endfunction

    initial begin
        rst_n  = 1'b0;
        idx    = '0;
        col_in = RGB_RED;
        mode   = MODE_STATIC;
        {bu, bd, bl, br} = 4'b0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_color", c_dut, 16'h0000);
        chk("reset_pos_x", x_dut, 42);
        chk("reset_pos_y", y_dut, 26);
        rst_n = 1'b1;

        // Static sweep: colour lag and square bounds
        cyc(2537);
        chk("static_left_of_sq", c_dut, 16'h0000);
        idx = 13'd2538;
        #1;
        chk("static_lag_before_edge", c_dut, 16'h0000);
        cyc(2538);
        chk("static_top_left", c_dut, 16'hF800);
        for (int f = 0; f < 2; f++) begin
            bad = 0;
            for (int i = 0; i < 6144; i++) begin
                cyc(i);
                exp_c = in_sq(i, 42, 26) ? 16'hF800 : 16'h0000;
                if (c_dut !== exp_c) bad++;
            end
            chk("static_sweep_bad_pixels", bad, 0);
        end
        chk("static_pos_x", x_dut, 42);
        chk("static_pos_y", y_dut, 26);

        // Manual: pulses collapse, clamping, cancellation
        mode = MODE_MANUAL;
        cyc(1);
        br = 1'b1; cyc(1); br = 1'b0; cyc(5);
        br = 1'b1; cyc(1); br = 1'b0; cyc(7);
        br = 1'b1; cyc(1); br = 1'b0;
        cyc(0);
        chk("manual_three_right_x", x_dut, 43);
        chk("manual_three_right_y", y_dut, 26);
        for (int i = 0; i < 43; i++) btn_frame(4'b0010);
        chk("manual_left_to_zero", x_dut, 0);
        btn_frame(4'b0010);
        chk("manual_left_clamp", x_dut, 0);
        btn_frame(4'b0011);
        chk("manual_left_right_cancel", x_dut, 0);
        btn_frame(4'b1100);
        chk("manual_up_down_cancel", y_dut, 26);
        btn_frame(4'b1000);
        chk("manual_up", y_dut, 25);

        // Pulse coinciding with the frame tick is deferred, not lost
        cyc(1);
        bd = 1'b1;
        cyc(0);
        bd = 1'b0;
        chk("tick_pulse_not_applied_yet", y_dut, 25);
        btn_frame(4'b0000);
        chk("tick_pulse_applied_next", y_dut, 26);

        // Reset mid-frame after moving
        for (int i = 0; i < 15; i++) btn_frame(4'b0001);
        chk("premove_x", x_dut, 15);
        cyc(3000);
        chk("premove_color_at_3000", c_dut, 16'hF800);
        rst_n = 1'b0;
        #1;
        chk("midreset_color", c_dut, 16'h0000);
        chk("midreset_pos_x", x_dut, 42);
        chk("midreset_pos_y", y_dut, 26);
        idx = 13'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("no_tick_after_reset", u_dut.u_tick.o_frame_tick, 0);
        cyc(0);
        cyc(1);
        idx = 13'd0;
        #1;
        chk("tick_on_return_to_zero", u_dut.u_tick.o_frame_tick, 1);
        cyc(0);

        // Bounce with FRAME_DIV=1: edge clamp and corner reversal
        mode = MODE_BOUNCE;
        cyc(1);
        btn_frame(4'b0000);
        chk("bounce1_x", x_bnc, 83);
        chk("bounce1_y", y_bnc, 27);
        chk("corner1_x", x_cor, 83);
        chk("corner1_y", y_cor, 51);
        btn_frame(4'b0000);
        chk("bounce2_x", x_bnc, 83);
        chk("bounce2_y", y_bnc, 28);
        chk("corner2_x", x_cor, 82);
        chk("corner2_y", y_cor, 50);
        btn_frame(4'b0000);
        chk("bounce3_x", x_bnc, 82);
        chk("bounce3_y", y_bnc, 29);
        chk("corner3_x", x_cor, 81);
        chk("corner3_y", y_cor, 49);

        // Blink with FRAME_DIV=2
        rst_n = 1'b0;
        cyc(0);
        rst_n = 1'b1;
        mode = MODE_BLINK;
        cyc(1);
        cyc(2538);
        chk("blink_frame0", c_blk, 16'hF800);
        btn_frame(4'b0000); cyc(2538);
        chk("blink_frame1", c_blk, 16'hF800);
        btn_frame(4'b0000); cyc(2538);
        chk("blink_frame2", c_blk, 16'h0000);
        btn_frame(4'b0000); cyc(2538);
        chk("blink_frame3", c_blk, 16'h0000);
        btn_frame(4'b0000); cyc(2538);
        chk("blink_frame4", c_blk, 16'hF800);
        btn_frame(4'b0000); cyc(2538);
        chk("blink_frame5", c_blk, 16'hF800);
        btn_frame(4'b0000); cyc(2538);
        chk("blink_frame6", c_blk, 16'h0000);
        mode = MODE_STATIC;
        cyc(2538);
        cyc(2538);
        chk("static_after_blink_visible", c_blk, 16'hF800);
        chk("blink_pos_x", x_blk, 42);
        chk("blink_pos_y", y_blk, 26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
